ec2_control_unit: RTL and testbench

- Moore/Mealy control FSM that sequences the 8-bit accumulator datapath of the enhanced processor through fetch, decode and execute.
- Drives the register-load, mux-select, memory and ALU controls.
- Handles the `enter` handshake for the IN instruction and parks the processor on HALT.
- Sits between the datapath (IR, PC, A, memory) and the top-level integration; its `state` and `ir_out` outputs feed the top-level `showstate`/`irOut` debug ports.

---
 rtl/ec2_control_unit.sv | 151 +++++++++++++++
 tb/tb_ec2_control_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ec2_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator processor; 1-cycle registered state, Mealy outputs on enter/flags.
// IN stalls on enter press and release; HALT parks until reset; reset forces every control low.
module ec2_control_unit #(
    parameter int COUNT_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enter,
    input  logic [7:0]         ir,
    input  logic               aeq0,
    input  logic               apos,
    output logic               ir_load,
    output logic               pc_load,
    output logic               jmp_mux,
    output logic               mem_inst,
    output logic               mem_wr,
    output logic [1:0]         a_sel,
    output logic               a_load,
    output logic               alu_sub,
    output logic               halt,
    output logic [2:0]         ir_out,
    output logic [3:0]         state,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_START = 4'b0000,
        S_FETCH = 4'b0001,
        S_DEC   = 4'b0010,
        S_INW   = 4'b0011,
        S_LOAD  = 4'b1000,
        S_STORE = 4'b1001,
        S_ADD   = 4'b1010,
        S_SUB   = 4'b1011,
        S_IN    = 4'b1100,
        S_JZ    = 4'b1101,
        S_JPOS  = 4'b1110,
        S_HALT  = 4'b1111
    } state_e;

    localparam logic [1:0] ASEL_ALU = 2'b00;
    localparam logic [1:0] ASEL_IN  = 2'b01;
    localparam logic [1:0] ASEL_MEM = 2'b10;

    state_e             state_q, state_d;
    logic [2:0]         ir_out_q, ir_out_d;
    logic [COUNT_W-1:0] count_q, count_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_START;
            ir_out_q <= 3'b000;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            ir_out_q <= ir_out_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_out_d = ir_out_q;
        count_d  = count_q;
        ir_load  = 1'b0;
        pc_load  = 1'b0;
        jmp_mux  = 1'b0;
        mem_inst = 1'b0;
        mem_wr   = 1'b0;
        a_sel    = ASEL_ALU;
        a_load   = 1'b0;
        alu_sub  = 1'b0;
        halt     = 1'b0;

        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                ir_load  = 1'b1;
                mem_inst = 1'b1;
                pc_load  = 1'b1;
                state_d  = S_DEC;
            end
            S_DEC: begin
                ir_out_d = ir[7:5];
                count_d  = count_q + COUNT_W'(1);
                state_d  = state_e'({1'b1, ir[7:5]});
            end
            S_LOAD: begin
                a_sel   = ASEL_MEM;
                a_load  = 1'b1;
                state_d = S_FETCH;
            end
            S_STORE: begin
                mem_wr  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADD: begin
                a_load  = 1'b1;
                state_d = S_FETCH;
            end
            S_SUB: begin
                alu_sub = 1'b1;
                a_load  = 1'b1;
                state_d = S_FETCH;
            end
            S_IN: begin
                if (enter) begin
                    a_sel   = ASEL_IN;
                    a_load  = 1'b1;
                    state_d = S_INW;
                end
            end
            // Wait for release so a held button loads A only once.
            S_INW: begin
                if (!enter) begin
                    state_d = S_FETCH;
                end
            end
            S_JZ: begin
                pc_load = aeq0;
                jmp_mux = aeq0;
                state_d = S_FETCH;
            end
            S_JPOS: begin
                pc_load = apos;
                jmp_mux = apos;
                state_d = S_FETCH;
            end
            S_HALT: halt = 1'b1;
            default: state_d = S_START;
        endcase

        // Reset masks the Mealy outputs too, so no stray A load while reset is held.
        if (reset) begin
            ir_load  = 1'b0;
            pc_load  = 1'b0;
            jmp_mux  = 1'b0;
            mem_inst = 1'b0;
            mem_wr   = 1'b0;
            a_sel    = ASEL_ALU;
            a_load   = 1'b0;
            alu_sub  = 1'b0;
            halt     = 1'b0;
        end
    end

    assign state       = state_q;
    assign ir_out      = ir_out_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_ec2_control_unit.sv
// Directed bench for ec2_control_unit: walks each instruction class, the IN handshake, HALT and reset corner cases.
module tb_ec2_control_unit;

    localparam int COUNT_W = 8;

    logic               clock;
    logic               reset;
    logic               enter;
    logic [7:0]         ir;
    logic               aeq0;
    logic               apos;
    logic               ir_load, pc_load, jmp_mux, mem_inst, mem_wr, a_load, alu_sub, halt;
    logic [1:0]         a_sel;
    logic [2:0]         ir_out;
    logic [3:0]         state;
    logic [COUNT_W-1:0] instr_count;
    logic [9:0]         ctrl;

    int tests_run;
    int tests_failed;
    int exp_cnt;

    // {ir_load, pc_load, jmp_mux, mem_inst, mem_wr, a_sel[1:0], a_load, alu_sub, halt}
    localparam logic [9:0] C_NONE  = 10'b0000000000;
    localparam logic [9:0] C_FETCH = 10'b1101000000;
    localparam logic [9:0] C_LOAD  = 10'b0000010100;
    localparam logic [9:0] C_STORE = 10'b0000100000;
    localparam logic [9:0] C_ADD   = 10'b0000000100;
    localparam logic [9:0] C_SUB   = 10'b0000000110;
    localparam logic [9:0] C_IN    = 10'b0000001100;
    localparam logic [9:0] C_JMP   = 10'b0110000000;
    localparam logic [9:0] C_HALT  = 10'b0000000001;

    ec2_control_unit #(.COUNT_W(COUNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .enter       (enter),
        .ir          (ir),
        .aeq0        (aeq0),
        .apos        (apos),
        .ir_load     (ir_load),
        .pc_load     (pc_load),
        .jmp_mux     (jmp_mux),
        .mem_inst    (mem_inst),
        .mem_wr      (mem_wr),
        .a_sel       (a_sel),
        .a_load      (a_load),
        .alu_sub     (alu_sub),
        .halt        (halt),
        .ir_out      (ir_out),
        .state       (state),
        .instr_count (instr_count)
    );

    assign ctrl = {ir_load, pc_load, jmp_mux, mem_inst, mem_wr, a_sel, a_load, alu_sub, halt};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Starts and ends in fetch; flags must be set up by the caller.
    task automatic do_instr(input logic [7:0] irv, input logic [3:0] exp_state, input logic [9:0] exp_ctrl);
        check("fetch_state", 32'(state), 32'h1);
        check("fetch_ctrl", 32'(ctrl), 32'(C_FETCH));
        ir = irv;
        step();
        check("dec_state", 32'(state), 32'h2);
        check("dec_ctrl", 32'(ctrl), 32'(C_NONE));
        step();
        exp_cnt = (exp_cnt + 1) % (1 << COUNT_W);
        check("exec_state", 32'(state), 32'(exp_state));
        check("exec_ctrl", 32'(ctrl), 32'(exp_ctrl));
        check("exec_irout", 32'(ir_out), 32'(irv[7:5]));
        check("exec_count", 32'(instr_count), 32'(exp_cnt));
        step();
        check("ret_state", 32'(state), 32'h1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_cnt      = 0;
        reset = 1'b1;
        enter = 1'b0;
        ir    = 8'h00;
        aeq0  = 1'b0;
        apos  = 1'b0;

        step();
        step();
        check("rst_state", 32'(state), 32'h0);
        check("rst_ctrl", 32'(ctrl), 32'(C_NONE));
        check("rst_irout", 32'(ir_out), 32'h0);
        check("rst_count", 32'(instr_count), 32'h0);
        reset = 1'b0;
        #1;
        check("s0_ctrl", 32'(ctrl), 32'(C_NONE));
        step();

        do_instr(8'h45, 4'b1010, C_ADD);
        do_instr(8'h12, 4'b1000, C_LOAD);
        do_instr(8'h33, 4'b1001, C_STORE);
        do_instr(8'h61, 4'b1011, C_SUB);

        // IN handshake: wait, press, hold, release
        ir = 8'h80;
        step();
        step();
        exp_cnt++;
        for (int i = 0; i < 5; i++) begin
            check("in_wait_state", 32'(state), 32'hC);
            check("in_wait_ctrl", 32'(ctrl), 32'(C_NONE));
            step();
        end
        enter = 1'b1;
        #1;
        check("in_press_ctrl", 32'(ctrl), 32'(C_IN));
        step();
        check("inw_state", 32'(state), 32'h3);
        for (int i = 0; i < 3; i++) begin
            check("inw_hold_ctrl", 32'(ctrl), 32'(C_NONE));
            step();
            check("inw_hold_state", 32'(state), 32'h3);
        end
        enter = 1'b0;
        #1;
        check("inw_rel_state", 32'(state), 32'h3);
        step();
        check("in_count", 32'(instr_count), 32'(exp_cnt));

        aeq0 = 1'b1;
        do_instr(8'hA7, 4'b1101, C_JMP);
        aeq0 = 1'b0;
        do_instr(8'hA7, 4'b1101, C_NONE);
        apos = 1'b1;
        do_instr(8'hC3, 4'b1110, C_JMP);
        apos = 1'b0;
        do_instr(8'hC3, 4'b1110, C_NONE);

        // HALT holds and freezes the counter
        ir = 8'hE0;
        step();
        step();
        exp_cnt++;
        for (int i = 0; i < 20; i++) begin
            check("halt_state", 32'(state), 32'hF);
            check("halt_ctrl", 32'(ctrl), 32'(C_HALT));
            check("halt_count", 32'(instr_count), 32'(exp_cnt));
            step();
        end
        reset = 1'b1;
        #1;
        check("halt_rst_ctrl", 32'(ctrl), 32'(C_NONE));
        step();
        exp_cnt = 0;
        check("halt_rst_state", 32'(state), 32'h0);
        check("halt_rst_count", 32'(instr_count), 32'h0);
        check("halt_rst_irout", 32'(ir_out), 32'h0);
        reset = 1'b0;
        step();

        // enter already high on entry, then reset before the load
        enter = 1'b1;
        ir = 8'h80;
        step();
        step();
        exp_cnt++;
        check("in_early_state", 32'(state), 32'hC);
        check("in_early_ctrl", 32'(ctrl), 32'(C_IN));
        reset = 1'b1;
        #1;
        check("in_rst_ctrl", 32'(ctrl), 32'(C_NONE));
        step();
        exp_cnt = 0;
        check("in_rst_state", 32'(state), 32'h0);
        reset = 1'b0;
        enter = 1'b0;
        step();

        // Counter wraps after 2^COUNT_W decodes
        ir = 8'h45;
        for (int i = 0; i < (1 << COUNT_W); i++) begin
            step();
            step();
            step();
        end
        check("wrap_state", 32'(state), 32'h1);
        check("wrap_count", 32'(instr_count), 32'h0);
        do_instr(8'h45, 4'b1010, C_ADD);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
